// File: rtl/packet_wrr_scheduler.sv
// Packet-level weighted round-robin scheduler for one router output port.
// Grants whole packets (head to TLAST), drives the output mux select and the
// per-channel TREADY gate, and releases a stuck grant through a beat watchdog.
// Optional feature macro: WRR_WEIGHTS_EN enables runtime per-channel weights
// and credits. Without it, the pointer advances after every packet.
module packet_wrr_scheduler #(
    parameter int CHANNEL_NUMBER       = 5,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
    parameter int WEIGHT_WIDTH         = 4,
    parameter int DEFAULT_WEIGHT       = 1,
    parameter int MAX_BEATS            = 256
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [CHANNEL_NUMBER-1:0]       valid_i,
    input  logic [CHANNEL_NUMBER-1:0]       last_i,
    input  logic                            out_ready_i,
    output logic [CHANNEL_NUMBER-1:0]       grant_o,
    output logic [CHANNEL_NUMBER_WIDTH-1:0] grant_idx_o,
    output logic                            busy_o,
    output logic                            abort_o,
    input  logic                            cfg_we_i,
    input  logic [CHANNEL_NUMBER_WIDTH-1:0] cfg_idx_i,
    input  logic [WEIGHT_WIDTH-1:0]         cfg_weight_i
);

    localparam int BEAT_WIDTH = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;

    typedef logic [CHANNEL_NUMBER_WIDTH-1:0] idx_t;
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state;
    idx_t                  ptr;
    logic [BEAT_WIDTH-1:0] beat_cnt;
    logic                  beat;
    logic                  pick_valid;
    idx_t                  pick_idx;
    idx_t                  cand_idx;
    int                    cand;

`ifdef WRR_WEIGHTS_EN
    logic [WEIGHT_WIDTH-1:0] weight [CHANNEL_NUMBER];
    logic [WEIGHT_WIDTH-1:0] credit [CHANNEL_NUMBER];
`else
    logic unused_cfg;
    assign unused_cfg = ^{cfg_we_i, cfg_idx_i, cfg_weight_i};
`endif

    // Successor index; CHANNEL_NUMBER need not be a power of two.
    function automatic idx_t next_idx(input idx_t i);
        return (int'(i) == CHANNEL_NUMBER - 1) ? '0 : i + idx_t'(1);
    endfunction

    assign beat = valid_i[grant_idx_o] & out_ready_i & grant_o[grant_idx_o];

    // Rotating priority search: first requesting channel at or after ptr.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        pick_valid = 1'b0;
        pick_idx   = ptr;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < CHANNEL_NUMBER; i++) begin
            cand = int'(ptr) + i;
            if (cand >= CHANNEL_NUMBER) cand = cand - CHANNEL_NUMBER;
            cand_idx = idx_t'(cand);
            if (!pick_valid && valid_i[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Grant FSM with registered outputs, watchdog, credits and weight config.
    always_ff @(posedge clk_i) begin
        // NOTE: state is written with <= so every read in this block sees the pre-edge value.
        if (rst_i) begin
            state       <= IDLE;
            grant_o     <= '0;
            grant_idx_o <= '0;
            busy_o      <= 1'b0;
            abort_o     <= 1'b0;
            ptr         <= '0;
            beat_cnt    <= '0;
`ifdef WRR_WEIGHTS_EN
            // NOTE: the small weight/credit arrays are reset because arbitration reads them at once.
            for (int i = 0; i < CHANNEL_NUMBER; i++) begin
                weight[i] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
                credit[i] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
            end
`endif
        end else begin
            abort_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state       <= LOCKED;
                        grant_idx_o <= pick_idx;
                        grant_o     <= {{(CHANNEL_NUMBER-1){1'b0}}, 1'b1} << pick_idx;
                        busy_o      <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (beat) begin
                        if (last_i[grant_idx_o]) begin
                            state    <= IDLE;
                            grant_o  <= '0;
                            busy_o   <= 1'b0;
                            beat_cnt <= '0;
`ifdef WRR_WEIGHTS_EN
                            if (credit[grant_idx_o] <= WEIGHT_WIDTH'(1)) begin
                                credit[grant_idx_o] <= weight[grant_idx_o];
                                ptr                 <= next_idx(grant_idx_o);
                            end else begin
                                credit[grant_idx_o] <= credit[grant_idx_o] - 1'b1;
                                ptr                 <= grant_idx_o;
                            end
`else
                            ptr <= next_idx(grant_idx_o);
`endif
                        end else if (beat_cnt == BEAT_WIDTH'(MAX_BEATS - 1)) begin
                            state    <= IDLE;
                            grant_o  <= '0;
                            busy_o   <= 1'b0;
                            abort_o  <= 1'b1;
                            beat_cnt <= '0;
                            ptr      <= next_idx(grant_idx_o);
`ifdef WRR_WEIGHTS_EN
                            credit[grant_idx_o] <= weight[grant_idx_o];
`endif
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef WRR_WEIGHTS_EN
            // Reload above reads the old weight when a write lands on the same edge.
            if (cfg_we_i && int'(cfg_idx_i) < CHANNEL_NUMBER) begin
                weight[cfg_idx_i] <= (cfg_weight_i == '0) ? WEIGHT_WIDTH'(1) : cfg_weight_i;
            end
`endif
        end
    end

endmodule

// File: tb/tb_packet_wrr_scheduler.sv
// Directed self-checking bench for packet_wrr_scheduler.
// The weighted-order scenario runs only when WRR_WEIGHTS_EN is defined.
module tb_packet_wrr_scheduler;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [4:0] valid_i;
    logic [4:0] last_i;
    logic       out_ready_i;
    logic [4:0] grant_o;
    logic [2:0] grant_idx_o;
    logic       busy_o;
    logic       abort_o;
    logic       cfg_we_i;
    logic [2:0] cfg_idx_i;
    logic [3:0] cfg_weight_i;

    int passed = 0;
    int total  = 0;

    packet_wrr_scheduler dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .last_i       (last_i),
        .out_ready_i  (out_ready_i),
        .grant_o      (grant_o),
        .grant_idx_o  (grant_idx_o),
        .busy_o       (busy_o),
        .abort_o      (abort_o),
        .cfg_we_i     (cfg_we_i),
        .cfg_idx_i    (cfg_idx_i),
        .cfg_weight_i (cfg_weight_i)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    int exp_rr  [6] = '{0, 1, 2, 3, 4, 0};
    int exp_wrr [8] = '{0, 1, 1, 1, 0, 1, 1, 1};

    initial begin
        rst_i        = 1'b1;
        valid_i      = '0;
        last_i       = '0;
        out_ready_i  = 1'b0;
        cfg_we_i     = 1'b0;
        cfg_idx_i    = '0;
        cfg_weight_i = '0;
        #1;
        do_reset();

        // Reset state
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_idx",   32'(grant_idx_o), 32'h0);
        check("rst_busy",  32'(busy_o), 32'h0);
        check("rst_abort", 32'(abort_o), 32'h0);

        // 3-beat packet on ch2
        valid_i = 5'b00100; out_ready_i = 1'b1;
        tick();
        check("t1_grant", 32'(grant_o), 32'h04);
        check("t1_idx",   32'(grant_idx_o), 32'd2);
        check("t1_busy",  32'(busy_o), 32'h1);
        tick();
        tick();
        check("t1_hold", 32'(grant_o), 32'h04);
        last_i = 5'b00100;
        tick();
        check("t1_release", 32'(grant_o), 32'h0);
        check("t1_busy_low", 32'(busy_o), 32'h0);
        valid_i = '0; last_i = '0;

        // Plain round robin over all channels, 1-beat packets
        do_reset();
        valid_i = 5'b11111; last_i = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("t2_idx%0d", k), 32'(grant_idx_o), 32'(exp_rr[k]));
            check($sformatf("t2_grant%0d", k), 32'(grant_o), 32'(5'b00001 << exp_rr[k]));
            tick();
            check($sformatf("t2_bubble%0d", k), 32'(grant_o), 32'h0);
        end
        valid_i = '0; last_i = '0;

`ifdef WRR_WEIGHTS_EN
        // weight[1]=3; one priming packet on ch1 reloads its credit with the new weight
        do_reset();
        cfg_we_i = 1'b1; cfg_idx_i = 3'd1; cfg_weight_i = 4'd3;
        valid_i = 5'b00010; last_i = 5'b00010;
        tick();
        cfg_we_i = 1'b0;
        check("t3_prime", 32'(grant_o), 32'h02);
        tick();
        valid_i = 5'b00011; last_i = 5'b00011;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("t3_idx%0d", k), 32'(grant_idx_o), 32'(exp_wrr[k]));
            tick();
        end
        valid_i = '0; last_i = '0;
`endif

        // Watchdog on ch2, then ch3 takes over
        do_reset();
        valid_i = 5'b00100; last_i = '0;
        tick();
        check("t4_grant", 32'(grant_o), 32'h04);
        valid_i = 5'b01100;
        for (int k = 0; k < 255; k++) tick();
        check("t4_hold255", 32'(grant_o), 32'h04);
        check("t4_no_abort", 32'(abort_o), 32'h0);
        tick();
        check("t4_abort", 32'(abort_o), 32'h1);
        check("t4_release", 32'(grant_o), 32'h0);
        tick();
        check("t4_abort_pulse", 32'(abort_o), 32'h0);
        check("t4_next_ch3", 32'(grant_o), 32'h08);
        last_i = 5'b01000;
        tick();
        check("t4_ch3_done", 32'(grant_o), 32'h0);
        valid_i = '0; last_i = '0;

        // Backpressure mid-packet on ch4
        do_reset();
        valid_i = 5'b10000;
        tick();
        tick();
        out_ready_i = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("t5_hold", 32'(grant_o), 32'h10);
        check("t5_busy", 32'(busy_o), 32'h1);
        out_ready_i = 1'b1; last_i = 5'b10000;
        tick();
        check("t5_done", 32'(grant_o), 32'h0);
        valid_i = '0; last_i = '0;

        // Move ptr to 3, lock ch4, then reset mid-packet
        valid_i = 5'b00100; last_i = 5'b00100;
        tick();
        tick();
        valid_i = 5'b10000; last_i = '0;
        tick();
        check("t6_grant4", 32'(grant_o), 32'h10);
        tick();
        rst_i = 1'b1; valid_i = 5'b10010;
        tick();
        check("t6_rst_grant", 32'(grant_o), 32'h0);
        check("t6_rst_busy",  32'(busy_o), 32'h0);
        check("t6_rst_idx",   32'(grant_idx_o), 32'h0);
        rst_i = 1'b0;
        tick();
        check("t6_lowest", 32'(grant_o), 32'h02);
        check("t6_lowest_idx", 32'(grant_idx_o), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
